rtc_bus_sequencer: RTL

Sequences single-byte read and write transactions on the RTC's multiplexed address/data bus (chip-select, read, write, address/data select, shared 8-bit AD lines). It arbitrates between two requesters: the periodic time-read engine on the read port and the user configuration path on the write port. It sits between those engines and the top-level RTC pins and enforces all strobe pulse and hold timing in clk_100MHz cycles.

---
 rtl/rtc_bus_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// -----------------
// Runs single-byte read and write transactions on the RTC's multiplexed
// address/data bus. Two requesters share the bus: the periodic time-read
// engine (read port) and the user configuration path (write port). They are
// arbitrated round-robin. Every strobe pulse and recovery gap is timed in
// clk_100MHz cycles by one 8-bit down-counter.
//
// Parameters
//   PULSE_CYC  strobe low width in cycles (1..255)
//   GAP_CYC    strobe-high hold/recovery after each pulse in cycles (1..255)
//
// Ports
//   clk_100MHz  system clock
//   reset_n     asynchronous active-low reset
//   rd_req      read request level, held until rd_grant
//   rd_addr     RTC register address for the read
//   rd_grant    one-cycle pulse: the read request was latched
//   rd_done     one-cycle pulse: rd_data holds the new byte
//   rd_data     last byte read, held until the next read completes
//   wr_req      write request level, held until wr_grant
//   wr_addr     RTC register address for the write
//   wr_data     byte to write
//   wr_grant    one-cycle pulse: the write request was latched
//   wr_done     one-cycle pulse: the write has finished
//   busy        high whenever a transaction is in flight
//   cs_n        RTC chip select, active low
//   rd_n        RTC read strobe, active low
//   wr_n        RTC write strobe, active low
//   a_d         0 = address phase, 1 = data phase
//   ad_out      AD bus drive value
//   ad_oe       AD bus drive enable (1 = drive)
//   ad_in       AD bus sampled value

module rtc_bus_sequencer #(
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic       rd_grant,
    output logic       rd_done,
    output logic [7:0] rd_data,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_grant,
    output logic       wr_done,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_PULSE,
        ADDR_HOLD,
        DATA_PULSE,
        DATA_HOLD
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       cur_is_read;
    logic [7:0] cur_data;
    logic [7:0] rd_hold;
    logic       last_was_write;
    logic       take_read;
    logic       accept;
    logic       cnt_last;

    // Round-robin pick: a lone request always wins. On a tie, the port that
    // was not served last wins. The pointer resets to "write served last",
    // so the read engine wins the first tie after reset.
    assign take_read = rd_req && (!wr_req || last_was_write);

    // A held request must not be re-issued in the cycle its done pulse is
    // high, because the requester has not yet seen the completion.
    assign accept = (rd_req || wr_req) && !rd_done && !wr_done;

    // Each timed state ends on the edge where the counter reads 1. A load of
    // N therefore yields exactly N cycles in that state.
    assign cnt_last = (cnt == 8'd1);

    // Single sequencer: state, timing counter and all bus pins are registered
    // together. Each transition sets the pin values for the state being
    // entered, so the pins change on the same edge as the state and never
    // depend combinationally on the request inputs. Reset forces the strobes
    // high and releases the AD bus immediately. It also discards any latched
    // transaction without a done pulse.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cur_is_read    <= 1'b0;
            cur_data       <= '0;
            rd_hold        <= '0;
            rd_data        <= '0;
            last_was_write <= 1'b1;
            rd_grant       <= 1'b0;
            wr_grant       <= 1'b0;
            rd_done        <= 1'b0;
            wr_done        <= 1'b0;
            busy           <= 1'b0;
            cs_n           <= 1'b1;
            rd_n           <= 1'b1;
            wr_n           <= 1'b1;
            a_d            <= 1'b1;
            ad_out         <= '0;
            ad_oe          <= 1'b0;
        end else begin
            rd_grant <= 1'b0;
            wr_grant <= 1'b0;
            rd_done  <= 1'b0;
            wr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_is_read    <= take_read;
                        cur_data       <= wr_data;
                        last_was_write <= !take_read;
                        rd_grant       <= take_read;
                        wr_grant       <= !take_read;
                        cnt            <= PULSE_LOAD;
                        busy           <= 1'b1;
                        state          <= ADDR_PULSE;
                        cs_n           <= 1'b0;
                        wr_n           <= 1'b0;
                        a_d            <= 1'b0;
                        ad_oe          <= 1'b1;
                        ad_out         <= take_read ? rd_addr : wr_addr;
                    end
                end
                ADDR_PULSE: begin
                    if (cnt_last) begin
                        state <= ADDR_HOLD;
                        cnt   <= GAP_LOAD;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ADDR_HOLD: begin
                    if (cnt_last) begin
                        state <= DATA_PULSE;
                        cnt   <= PULSE_LOAD;
                        cs_n  <= 1'b0;
                        a_d   <= 1'b1;
                        if (cur_is_read) begin
                            rd_n  <= 1'b0;
                            ad_oe <= 1'b0;
                        end else begin
                            wr_n   <= 1'b0;
                            ad_out <= cur_data;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DATA_PULSE: begin
                    if (cnt_last) begin
                        state <= DATA_HOLD;
                        cnt   <= GAP_LOAD;
                        cs_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        if (cur_is_read) begin
                            rd_hold <= ad_in;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DATA_HOLD: begin
                    if (cnt_last) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        ad_oe   <= 1'b0;
                        rd_done <= cur_is_read;
                        wr_done <= !cur_is_read;
                        if (cur_is_read) begin
                            rd_data <= rd_hold;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
